mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline. It sits between EX and WB. It accepts one instruction per handshake from EX and waits for the data-SRAM response when the instruction is a load. It extracts and sign- or zero-extends the loaded byte, half or word, and then sends the 70-bit result bus that WB consumes. It also drives the MEM-stage forwarding and load-use information back to decode.

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/mem_stage_load_extend.sv | 20 ++
 rtl/mem_stage.sv | 75 +++++++
 tb/tb_mem_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: pipeline bus widths, EX->MEM bus field offsets and load-type encodings
package mem_stage_pkg;
    localparam int ES_TO_MS_W = 74;
    localparam int MS_TO_WS_W = 70;
    localparam int BUS_PC_LSB = 0;
    localparam int BUS_ALU_LSB = 32;
    localparam int BUS_DEST_LSB = 64;
    localparam int BUS_GR_WE = 69;
    localparam int BUS_LD_TYPE_LSB = 70;
    localparam int BUS_RES_FROM_MEM = 73;
    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b100,
        LD_HU = 3'b101
    } ld_type_e;
endpackage

// File: rtl/mem_stage_load_extend.sv
// mem_stage_load_extend: selects the addressed byte/half/word of a load and sign- or zero-extends it
module mem_stage_load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  ld_type_i,
    output logic [31:0] result_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = raw_i[{addr_i, 3'b000} +: 8];
    // a[0] is ignored for halves; alignment is checked upstream
    assign half_v = addr_i[1] ? raw_i[31:16] : raw_i[15:0];
    assign result_o = (ld_type_i == LD_B)  ? {{24{byte_v[7]}}, byte_v} :
                      (ld_type_i == LD_BU) ? {24'b0, byte_v} :
                      (ld_type_i == LD_H)  ? {{16{half_v[15]}}, half_v} :
                      (ld_type_i == LD_HU) ? {16'b0, half_v} : raw_i;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; waits for load data, buffers a response WB cannot yet take,
// and forwards the completed result to decode
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  es_to_ms_valid,
    input  logic [ES_TO_MS_W-1:0] es_to_ms_bus,
    output logic                  ms_allowin,
    input  logic                  data_sram_data_ok,
    input  logic [31:0]           data_sram_rdata,
    input  logic                  ws_allowin,
    output logic                  ms_to_ws_valid,
    output logic [MS_TO_WS_W-1:0] ms_to_ws_bus,
    output logic [4:0]            ms_to_ds_dest,
    output logic [31:0]           ms_to_ds_value,
    output logic                  ms_to_ds_load_pending
);
    logic                  ms_valid_q, ms_valid_d, buf_valid_q, buf_valid_d;
    logic [ES_TO_MS_W-1:0] bus_q, bus_d;
    logic [31:0]           buf_q, buf_d, raw, load_res, final_result, alu_result, pc;
    logic                  res_from_mem, gr_we, ready_go, fwd, buf_set;
    logic [2:0]            ld_type;
    logic [4:0]            dest;

    assign res_from_mem = bus_q[BUS_RES_FROM_MEM];
    assign ld_type      = bus_q[BUS_LD_TYPE_LSB +: 3];
    assign gr_we        = bus_q[BUS_GR_WE];
    assign dest         = bus_q[BUS_DEST_LSB +: 5];
    assign alu_result   = bus_q[BUS_ALU_LSB +: 32];
    assign pc           = bus_q[BUS_PC_LSB +: 32];

    assign ready_go       = !res_from_mem || data_sram_data_ok || buf_valid_q;
    assign ms_allowin     = !ms_valid_q || (ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ready_go;
    // data_ok is a one-cycle pulse, so keep it if WB stalls; a stray pulse never lands here
    assign buf_set = data_sram_data_ok && ms_valid_q && res_from_mem && !buf_valid_q && !ws_allowin;
    assign raw     = buf_valid_q ? buf_q : data_sram_rdata;

    mem_stage_load_extend u_load_extend (
        .raw_i     (raw),
        .addr_i    (alu_result[1:0]),
        .ld_type_i (ld_type),
        .result_o  (load_res)
    );

    assign final_result          = res_from_mem ? load_res : alu_result;
    assign ms_to_ws_bus          = {gr_we, dest, final_result, pc};
    assign fwd                   = ms_valid_q && gr_we && ready_go;
    assign ms_to_ds_dest         = fwd ? dest : 5'd0;
    assign ms_to_ds_value        = fwd ? final_result : 32'd0;
    assign ms_to_ds_load_pending = ms_valid_q && res_from_mem && !ready_go;

    always_comb begin
        ms_valid_d  = ms_allowin ? es_to_ms_valid : ms_valid_q;
        bus_d       = (ms_allowin && es_to_ms_valid) ? es_to_ms_bus : bus_q;
        buf_d       = buf_set ? data_sram_rdata : buf_q;
        buf_valid_d = buf_set || (buf_valid_q && !(ms_to_ws_valid && ws_allowin));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            bus_q       <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            bus_q       <= bus_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        es_to_ms_valid = 1'b0;
    logic [73:0] es_to_ms_bus = '0;
    logic        ms_allowin;
    logic        data_sram_data_ok = 1'b0;
    logic [31:0] data_sram_rdata = '0;
    logic        ws_allowin = 1'b1;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [4:0]  ms_to_ds_dest;
    logic [31:0] ms_to_ds_value;
    logic        ms_to_ds_load_pending;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk                   (clk),
        .resetn                (resetn),
        .es_to_ms_valid        (es_to_ms_valid),
        .es_to_ms_bus          (es_to_ms_bus),
        .ms_allowin            (ms_allowin),
        .data_sram_data_ok     (data_sram_data_ok),
        .data_sram_rdata       (data_sram_rdata),
        .ws_allowin            (ws_allowin),
        .ms_to_ws_valid        (ms_to_ws_valid),
        .ms_to_ws_bus          (ms_to_ws_bus),
        .ms_to_ds_dest         (ms_to_ds_dest),
        .ms_to_ds_value        (ms_to_ds_value),
        .ms_to_ds_load_pending (ms_to_ds_load_pending)
    );

    function automatic logic [73:0] mk(input logic r, input logic [2:0] t, input logic we,
                                       input logic [4:0] d, input logic [31:0] alu, input logic [31:0] pc);
        return {r, t, we, d, alu, pc};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got=%0b exp=1", ms_allowin); end
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", ms_to_ws_valid); end
        checks++; if (ms_to_ds_dest !== 5'd0 || ms_to_ds_value !== 32'd0) begin errors++; $display("FAIL reset_fwd got=%0d/%h exp=0/0", ms_to_ds_dest, ms_to_ds_value); end
        checks++; if (ms_to_ds_load_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%0b exp=0", ms_to_ds_load_pending); end
        checks++; if (ms_to_ws_bus !== 70'd0) begin errors++; $display("FAIL reset_bus got=%h exp=0", ms_to_ws_bus); end
        @(posedge clk); #1 resetn = 1'b1;
    endtask

    task automatic test_non_load();
        @(posedge clk); #1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(1'b0, 3'b000, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_0100);
        @(posedge clk); #1 es_to_ms_valid = 1'b0;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL nonload_valid got=%0b exp=1", ms_to_ws_valid); end
        checks++; if (ms_to_ws_bus !== {1'b1, 5'd5, 32'h1234_5678, 32'h0000_0100}) begin errors++; $display("FAIL nonload_bus got=%h", ms_to_ws_bus); end
        checks++; if (ms_to_ds_dest !== 5'd5 || ms_to_ds_value !== 32'h1234_5678) begin errors++; $display("FAIL nonload_fwd got=%0d/%h exp=5/12345678", ms_to_ds_dest, ms_to_ds_value); end
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0 || ms_to_ds_dest !== 5'd0) begin errors++; $display("FAIL nonload_leave got=%0b/%0d exp=0/0", ms_to_ws_valid, ms_to_ds_dest); end
    endtask

    task automatic test_load_extend();
        logic [2:0]  t[7]   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011, 3'b001};
        logic [31:0] a[7]   = '{32'h3, 32'h3, 32'h2, 32'h0, 32'h1, 32'h0, 32'h3};
        logic [31:0] d[7]   = '{32'h80FF_0011, 32'h80FF_0011, 32'h8001_7FFF, 32'h8001_7FFF, 32'hCAFE_F00D, 32'h1357_9BDF, 32'h7ABC_8000};
        logic [31:0] exp[7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_7FFF, 32'hCAFE_F00D, 32'h1357_9BDF, 32'h0000_7ABC};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            es_to_ms_valid = 1'b1;
            es_to_ms_bus = mk(1'b1, t[i], 1'b1, 5'd7, a[i], 32'h300 + 32'(i));
            @(posedge clk); #1 es_to_ms_valid = 1'b0;
            @(negedge clk);
            checks++; if (ms_to_ds_load_pending !== 1'b1 || ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL ld%0d_wait got=pend%0b allow%0b valid%0b", i, ms_to_ds_load_pending, ms_allowin, ms_to_ws_valid); end
            @(posedge clk); #1;
            data_sram_data_ok = 1'b1;
            data_sram_rdata = d[i];
            @(negedge clk);
            checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== exp[i]) begin errors++; $display("FAIL ld%0d_result got=%0b/%h exp=1/%h", i, ms_to_ws_valid, ms_to_ws_bus[63:32], exp[i]); end
            checks++; if (ms_to_ds_dest !== 5'd7 || ms_to_ds_value !== exp[i]) begin errors++; $display("FAIL ld%0d_fwd got=%0d/%h exp=7/%h", i, ms_to_ds_dest, ms_to_ds_value, exp[i]); end
            @(posedge clk); #1 data_sram_data_ok = 1'b0;
        end
    endtask

    task automatic test_late_load();
        @(posedge clk); #1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(1'b1, 3'b010, 1'b1, 5'd9, 32'h40, 32'h400);
        @(posedge clk); #1 es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (ms_to_ds_load_pending !== 1'b1 || ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL late_wait%0d got=pend%0b allow%0b valid%0b", i, ms_to_ds_load_pending, ms_allowin, ms_to_ws_valid); end
            @(posedge clk); #1;
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== {1'b1, 5'd9, 32'h0BAD_F00D, 32'h400}) begin errors++; $display("FAIL late_handoff got=%0b/%h", ms_to_ws_valid, ms_to_ws_bus); end
        checks++; if (ms_to_ds_load_pending !== 1'b0 || ms_allowin !== 1'b1) begin errors++; $display("FAIL late_release got=pend%0b allow%0b exp=0/1", ms_to_ds_load_pending, ms_allowin); end
        @(posedge clk); #1 data_sram_data_ok = 1'b0;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL late_single got=%0b exp=0", ms_to_ws_valid); end
    endtask

    task automatic test_buffer();
        int pulses = 0;
        @(posedge clk); #1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(1'b1, 3'b010, 1'b1, 5'd3, 32'h80, 32'h500);
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
        ws_allowin = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h1122_3344;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin errors++; $display("FAIL buf_stall got=valid%0b allow%0b exp=1/0", ms_to_ws_valid, ms_allowin); end
        @(posedge clk); #1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h1122_3344 || ms_allowin !== 1'b0) begin errors++; $display("FAIL buf_hold%0d got=%0b/%h/%0b exp=1/11223344/0", i, ms_to_ws_valid, ms_to_ws_bus[63:32], ms_allowin); end
            if (i == 1) begin
                data_sram_data_ok = 1'b1;
                data_sram_rdata = 32'h5555_AAAA;
            end
            @(posedge clk); #1;
        end
        data_sram_data_ok = 1'b0;
        ws_allowin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ms_to_ws_valid === 1'b1) begin
                pulses++;
                checks++; if (ms_to_ws_bus[63:32] !== 32'h1122_3344) begin errors++; $display("FAIL buf_deliver got=%h exp=11223344", ms_to_ws_bus[63:32]); end
            end
            @(posedge clk); #1;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL buf_once got=%0d exp=1", pulses); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        es_to_ms_valid = 1'b1;
        data_sram_data_ok = 1'b1;
        es_to_ms_bus = mk(1'b1, 3'b010, 1'b1, 5'd10, 32'h0, 32'h200);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            es_to_ms_valid = (i < 3);
            es_to_ms_bus = mk(1'b1, 3'b010, 1'b1, 5'd10 + 5'(i + 1), 32'h0, 32'h200 + 32'(4 * (i + 1)));
            data_sram_rdata = 32'hA0 + 32'(i);
            @(negedge clk);
            checks++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1 || ms_to_ws_bus[31:0] !== 32'h200 + 32'(4 * i) || ms_to_ws_bus[63:32] !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL b2b%0d got=%0b/%0b pc=%h d=%h", i, ms_to_ws_valid, ms_allowin, ms_to_ws_bus[31:0], ms_to_ws_bus[63:32]); end
        end
        @(posedge clk); #1 data_sram_data_ok = 1'b0;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0b exp=0", ms_to_ws_valid); end
    endtask

    task automatic test_reset_mid_load();
        @(posedge clk); #1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(1'b1, 3'b000, 1'b1, 5'd12, 32'h1, 32'h600);
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0 || ms_to_ds_load_pending !== 1'b0 || ms_to_ds_dest !== 5'd0 || ms_to_ds_value !== 32'd0) begin errors++; $display("FAIL rstmid_drop got=allow%0b valid%0b pend%0b dest%0d", ms_allowin, ms_to_ws_valid, ms_to_ds_load_pending, ms_to_ds_dest); end
        @(posedge clk); #1;
        resetn = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h7777_7777;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0 || ms_to_ds_dest !== 5'd0 || ms_to_ds_value !== 32'd0 || ms_to_ds_load_pending !== 1'b0) begin errors++; $display("FAIL rstmid_stray got=valid%0b dest%0d val%h", ms_to_ws_valid, ms_to_ds_dest, ms_to_ds_value); end
        @(posedge clk); #1 data_sram_data_ok = 1'b0;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || ms_to_ws_bus !== 70'd0) begin errors++; $display("FAIL rstmid_after got=valid%0b allow%0b bus=%h", ms_to_ws_valid, ms_allowin, ms_to_ws_bus); end
    endtask

    initial begin
        test_reset();
        test_non_load();
        test_load_extend();
        test_late_load();
        test_buffer();
        test_back_to_back();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
